// File: rtl/shift_issue_stage_if.sv
// Issue-side handshake bundle for the shift execute stage: upstream op
// offer (valid/ready + operands), downstream result (valid/ready + data),
// and the pipeline kill. The producer/consumer side uses "master", the
// stage itself uses "slave".
interface shift_issue_if #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) ();
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [XLEN-1:0]    in_rs1;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output flush, in_valid, in_op, in_rs1, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_rs1, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Two-stage execute wrapper around an external combinational left shifter.
// S1 holds the operand (bit-reversed for right shifts), S2 holds the
// post-processed result. Right shifts reuse the left shifter: reverse,
// shift left, reverse back, then OR in a sign-fill mask for SRA.
module shift_issue_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_issue_if.slave       bus,
    output logic [XLEN-1:0]    shl_a,
    output logic [SHAMT_W-1:0] shl_b,
    input  logic [XLEN-1:0]    shl_out
);
    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction

    // S1 (operand) registers
    logic               r_s1_valid;
    op_e                r_s1_op;
    logic [XLEN-1:0]    r_s1_a;
    logic [SHAMT_W-1:0] r_s1_shamt;
    logic [TAG_W-1:0]   r_s1_tag;
    logic               r_s1_sign;

    // S2 (result) registers
    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_result;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_s2_take;
    logic               w_accept;
    logic               w_s1_move;
    op_e                w_in_op;
    logic [XLEN-1:0]    w_in_a;
    logic [XLEN-1:0]    w_sra_mask;
    logic [XLEN-1:0]    w_result;

    // S2 can take a new entry when it is empty or being drained this cycle.
    assign w_s2_take    = !r_out_valid || bus.out_ready;
    assign bus.in_ready = !bus.flush && (!r_s1_valid || w_s2_take);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_s1_move    = r_s1_valid && w_s2_take;

    assign w_in_op = op_e'(bus.in_op);
    assign w_in_a  = (w_in_op == OP_SRL || w_in_op == OP_SRA) ? bitrev(bus.in_rs1) : bus.in_rs1;

    // Shifter operands come only from S1, so a stall keeps them steady.
    assign shl_a = r_s1_a;
    assign shl_b = r_s1_shamt;

    // Top s1_shamt bits set; zero when the amount is zero.
    assign w_sra_mask = ~({XLEN{1'b1}} >> r_s1_shamt);

    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_tag    = r_out_tag;

    // Post-process the shifter output according to the held op.
    always_comb begin
        // NOTE: default first so every path assigns w_result and no latch is inferred.
        w_result = shl_out;
        case (r_s1_op)
            OP_SLL:  w_result = shl_out;
            OP_SRL:  w_result = bitrev(shl_out);
            OP_SRA:  w_result = bitrev(shl_out) | (r_s1_sign ? w_sra_mask : '0);
            OP_PASS: w_result = r_s1_a;
        endcase
    end

    // S1: capture an accepted op; empty out when it moves on or is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_SLL;
            r_s1_a     <= '0;
            r_s1_shamt <= '0;
            r_s1_tag   <= '0;
            r_s1_sign  <= 1'b0;
        end else begin
            if (bus.flush)       r_s1_valid <= 1'b0;
            else if (w_accept)   r_s1_valid <= 1'b1;
            else if (w_s2_take)  r_s1_valid <= 1'b0;

            if (w_accept) begin
                r_s1_op    <= w_in_op;
                r_s1_a     <= w_in_a;
                r_s1_shamt <= bus.in_shamt;
                r_s1_tag   <= bus.in_tag;
                r_s1_sign  <= bus.in_rs1[XLEN-1];
            end
        end
    end

    // S2: load the finished result from S1 whenever S2 is free to take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else begin
            if (bus.flush)      r_out_valid <= 1'b0;
            else if (w_s2_take) r_out_valid <= r_s1_valid;

            if (w_s1_move && !bus.flush) begin
                r_out_result <= w_result;
                r_out_tag    <= r_s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage. An ideal left shifter closes the
// shl_a/shl_b -> shl_out loop. A queue model predicts every result from
// plain shift operators; literal checks pin the model on known vectors.
module tb_shift_issue_stage;
    logic        clk;
    logic        rst_n;
    logic [31:0] shl_a;
    logic [4:0]  shl_b;
    logic [31:0] shl_out;

    shift_issue_if #(.XLEN(32), .SHAMT_W(5), .TAG_W(5)) bus ();

    shift_issue_stage #(.XLEN(32), .SHAMT_W(5), .TAG_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .shl_a   (shl_a),
        .shl_b   (shl_b),
        .shl_out (shl_out)
    );

    assign shl_out = shl_a << shl_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int edges    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] v, input int sh);
        logic signed [31:0] s;
        s = v;
        case (op)
            2'b00:   return v << sh;
            2'b01:   return v >> sh;
            2'b10:   return s >>> sh;
            default: return v;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          stamp;
    } item_t;

    item_t q[$];

    always @(posedge clk) edges++;

    // Compare process: sampled on the falling edge, inputs change after the rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            check("in_ready", 32'(bus.in_ready),
                  32'(!bus.flush && (q.size() < 2 || bus.out_ready)));
            check("out_valid", 32'(bus.out_valid),
                  32'(q.size() > 0 && edges >= q[0].stamp + 1));
            if (bus.out_valid && q.size() > 0) begin
                check("out_result", bus.out_result, q[0].res);
                check("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
            if (bus.flush) q.delete();
            if (bus.in_valid && bus.in_ready)
                q.push_back('{model(bus.in_op, bus.in_rs1, int'(bus.in_shamt)), bus.in_tag, edges + 1});
        end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] rs1, input logic [4:0] sh, input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = rs1;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for the offered op to be taken; returns at rising edge + 1.
    task automatic wait_accept(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // One op into an empty pipe with out_ready=1: S1 only after the accept edge,
    // result visible after the following edge.
    task automatic single(input string name, input logic [1:0] op, input logic [31:0] rs1,
                          input logic [4:0] sh, input logic [4:0] tag, input logic [31:0] exp);
        drive(op, rs1, sh, tag);
        wait_accept(name);
        idle();
        @(negedge clk);
        check({name, "_lat_s1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({name, "_lat_s2"}, 32'(bus.out_valid), 32'd1);
        check({name, "_result"}, bus.out_result, exp);
        check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_rs1    = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-op vectors with literal results and latency.
        single("sll10",   2'b00, 32'h0FFA05FF, 5'd10, 5'd1, 32'hE817FC00);
        single("srl4",    2'b01, 32'h80000000, 5'd4,  5'd2, 32'h08000000);
        single("sra4",    2'b10, 32'h80000000, 5'd4,  5'd3, 32'hF8000000);
        single("sra0",    2'b10, 32'h80000001, 5'd0,  5'd4, 32'h80000001);
        single("sra31",   2'b10, 32'h80000000, 5'd31, 5'd5, 32'hFFFFFFFF);
        single("sll0",    2'b00, 32'hA5A5A5A5, 5'd0,  5'd6, 32'hA5A5A5A5);
        single("srl0",    2'b01, 32'hA5A5A5A5, 5'd0,  5'd7, 32'hA5A5A5A5);
        single("pass",    2'b11, 32'h12345678, 5'd9,  5'd8, 32'h12345678);
        single("sra_pos", 2'b10, 32'h7FFFFFFF, 5'd31, 5'd9, 32'h00000000);

        // Back-to-back four ops at full rate.
        base = n_out;
        drive(2'b00, 32'h00000001, 5'd1, 5'd10); wait_accept("b2b0");
        drive(2'b01, 32'h000000F0, 5'd4, 5'd11); wait_accept("b2b1");
        drive(2'b10, 32'hFFFFFF00, 5'd8, 5'd12); wait_accept("b2b2");
        drive(2'b11, 32'h12345678, 5'd7, 5'd13); wait_accept("b2b3");
        idle();
        repeat (4) @(negedge clk);
        check("b2b_count", 32'(n_out - base), 32'd4);
        @(posedge clk);
        #1;

        // Backpressure: two held, third refused, result frozen, then drain.
        base = n_out;
        bus.out_ready = 1'b0;
        drive(2'b00, 32'h00000001, 5'd4,  5'd1); wait_accept("bp_a");
        drive(2'b10, 32'h80000000, 5'd1,  5'd2); wait_accept("bp_b");
        drive(2'b01, 32'hFFFFFFFF, 5'd31, 5'd3);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_frozen_result", bus.out_result, 32'h00000010);
            check("bp_frozen_tag", 32'(bus.out_tag), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept("bp_c");
        idle();
        repeat (5) @(negedge clk);
        check("bp_count", 32'(n_out - base), 32'd3);
        @(posedge clk);
        #1;

        // Flush with both stages full.
        bus.out_ready = 1'b0;
        drive(2'b00, 32'h0000000F, 5'd2, 5'd20); wait_accept("fl_a");
        drive(2'b01, 32'hF0000000, 5'd2, 5'd21); wait_accept("fl_b");
        idle();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        base = n_out;
        @(negedge clk);
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("fl_no_stale", 32'(n_out - base), 32'd0);
        @(posedge clk);
        #1;
        single("post_flush", 2'b10, 32'hC0000000, 5'd3, 5'd22, 32'hF8000000);

        // Reset with ops in flight.
        bus.out_ready = 1'b0;
        drive(2'b00, 32'h00000003, 5'd5, 5'd25); wait_accept("rs_a");
        drive(2'b00, 32'h00000005, 5'd6, 5'd26); wait_accept("rs_b");
        idle();
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_out_result", bus.out_result, 32'd0);
        check("rs_out_tag", 32'(bus.out_tag), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        base = n_out;
        repeat (4) @(negedge clk);
        check("rs_no_stale", 32'(n_out - base), 32'd0);
        @(posedge clk);
        #1;
        single("post_reset", 2'b01, 32'h0000FF00, 5'd8, 5'd27, 32'h000000FF);

        repeat (2) @(posedge clk);
        check("model_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
